r5p_ifu: RTL and testbench

R5P_IFU -- requirements
Module: r5p_ifu

---
 rtl/r5p_ifu.sv | 161 ++++++++++++++++
 tb/tb_r5p_ifu.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/r5p_ifu.sv
// r5p_ifu: instruction fetch unit with a word prefetch queue and a redirect port.
// Define R5P_IFU_RVC_EN to add compressed (16-bit) instruction support.
module r5p_ifu #(
    parameter int unsigned    IAW   = 32,
    parameter int unsigned    DEPTH = 4,
    parameter logic [IAW-1:0] PC0   = IAW'(32'h0000_0000)
) (
    input  logic           clk,
    input  logic           rst,
    output logic           if_vld,
    output logic [IAW-1:0] if_adr,
    input  logic [31:0]    if_rdt,
    input  logic           if_rdy,
    output logic           dec_vld,
    input  logic           dec_rdy,
    output logic [IAW-1:0] dec_pc,
    output logic [31:0]    dec_ins,
    output logic [2:0]     dec_siz,
    input  logic           jmp_vld,
    input  logic [IAW-1:0] jmp_adr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic           run_q;
    logic [IAW-1:0] fadr_q, fadr_d;
    logic           rsp_q, rsp_d;
    logic           dsc_q, dsc_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [AW-1:0]  wr_q, wr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IAW-1:0] pc_q, pc_d;
    logic [31:0]    mem_q [DEPTH];

    logic           hs;
    logic           push;
    logic           take;
    logic           pop;
    logic [IAW-1:0] jmp_pc;
    logic [31:0]    head;

    assign head = mem_q[rd_q];

    // A discarded in-flight response never holds a queue credit.
    assign if_vld = run_q & ((cnt_q + CW'(rsp_q & ~dsc_q)) < CW'(DEPTH));
    assign if_adr = fadr_q;
    assign dec_pc = pc_q;

    assign hs   = if_vld & if_rdy;
    assign push = rsp_q & ~dsc_q & ~jmp_vld;
    assign take = dec_vld & dec_rdy;

`ifdef R5P_IFU_RVC_EN
    logic           hof_q, hof_d;
    logic [AW-1:0]  rd1;
    logic [15:0]    nxt_lo;
    logic [15:0]    par;
    logic           is16;

    assign rd1    = rd_q + AW'(1);
    assign nxt_lo = mem_q[rd1][15:0];
    assign par    = hof_q ? head[31:16] : head[15:0];
    assign is16   = par[1:0] != 2'b11;

    // A 32-bit instruction straddling two words needs both of them queued.
    assign dec_vld = (is16 || !hof_q) ? (cnt_q != '0) : (cnt_q >= CW'(2));
    assign dec_ins = is16 ? {16'h0000, par} : (hof_q ? {nxt_lo, head[31:16]} : head);
    assign dec_siz = (dec_vld && is16) ? 3'd2 : 3'd4;
    assign pop     = take & (~is16 | hof_q);
    assign jmp_pc  = jmp_adr & ~IAW'(1);
`else
    assign dec_vld = cnt_q != '0;
    assign dec_ins = head;
    assign dec_siz = 3'd4;
    assign pop     = take;
    assign jmp_pc  = jmp_adr & ~IAW'(3);
`endif

    // Next-state: a redirect overrides push, pop and the fetch increment.
    always_comb begin
        fadr_d = fadr_q;
        rsp_d  = hs;
        dsc_d  = jmp_vld;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        pc_d   = pc_q;
`ifdef R5P_IFU_RVC_EN
        hof_d  = hof_q;
`endif
        if (jmp_vld) begin
            fadr_d = jmp_adr & ~IAW'(3);
            rd_d   = '0;
            wr_d   = '0;
            cnt_d  = '0;
            pc_d   = jmp_pc;
`ifdef R5P_IFU_RVC_EN
            hof_d  = jmp_adr[1];
`endif
        end else begin
            if (hs) begin
                fadr_d = fadr_q + IAW'(4);
            end
            if (push) begin
                wr_d = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            if (take) begin
                pc_d = pc_q + IAW'(dec_siz);
`ifdef R5P_IFU_RVC_EN
                hof_d = hof_q ^ is16;
`endif
            end
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            fadr_q <= PC0 & ~IAW'(3);
            rsp_q  <= 1'b0;
            dsc_q  <= 1'b0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            pc_q   <= PC0;
`ifdef R5P_IFU_RVC_EN
            hof_q  <= PC0[1];
`endif
        end else begin
            run_q  <= 1'b1;
            fadr_q <= fadr_d;
            rsp_q  <= rsp_d;
            dsc_q  <= dsc_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            pc_q   <= pc_d;
`ifdef R5P_IFU_RVC_EN
            hof_q  <= hof_d;
`endif
        end
    end

    // Queue storage, cleared on reset so the decoder sees zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_q] <= if_rdt;
        end
    end

endmodule

// File: tb/tb_r5p_ifu.sv
// tb_r5p_ifu: randomized scoreboard bench for r5p_ifu against an instruction-stream model.
// Honours R5P_IFU_RVC_EN in the same way as the design.
module tb_r5p_ifu;

    localparam int unsigned IAW   = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] PC0   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_vld;
    logic [31:0] if_adr;
    logic [31:0] if_rdt = '0;
    logic        if_rdy = 1'b0;
    logic        dec_vld;
    logic        dec_rdy = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_ins;
    logic [2:0]  dec_siz;
    logic        jmp_vld = 1'b0;
    logic [31:0] jmp_adr = '0;

    always #5 clk = ~clk;

    r5p_ifu #(.IAW(IAW), .DEPTH(DEPTH), .PC0(PC0)) dut (
        .clk(clk), .rst(rst),
        .if_vld(if_vld), .if_adr(if_adr), .if_rdt(if_rdt), .if_rdy(if_rdy),
        .dec_vld(dec_vld), .dec_rdy(dec_rdy), .dec_pc(dec_pc),
        .dec_ins(dec_ins), .dec_siz(dec_siz),
        .jmp_vld(jmp_vld), .jmp_adr(jmp_adr)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [2:0]  siz;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] gen_pc;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_consumed = 0;
    int          cyc = 0;
    logic        hs_pend = 1'b0;
    logic [31:0] hs_adr = '0;
    logic        pv_ok = 1'b0;

    function automatic logic [31:0] mem32(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        return (w * 32'h9E37_79B1) ^ {w[15:0], w[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [15:0] mem16(input logic [31:0] a);
        logic [31:0] w;
        w = mem32(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // What the decoder must see for an instruction starting at pc.
    function automatic exp_t model(input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
`ifdef R5P_IFU_RVC_EN
        begin
            logic [15:0] lo;
            lo = mem16(pc);
            if (lo[1:0] != 2'b11) begin
                e.ins = {16'h0000, lo};
                e.siz = 3'd2;
            end else begin
                e.ins = {mem16(pc + 32'd2), lo};
                e.siz = 3'd4;
            end
        end
`else
        e.ins = mem32(pc);
        e.siz = 3'd4;
`endif
        return e;
    endfunction

    function automatic logic [31:0] jmp_target(input logic [31:0] a);
`ifdef R5P_IFU_RVC_EN
        return a & ~32'h1;
`else
        return a & ~32'h3;
`endif
    endfunction

    task automatic refill();
        exp_t e;
        while (expq.size() < 16) begin
            e = model(gen_pc);
            expq.push_back(e);
            gen_pc = gen_pc + 32'(e.siz);
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        expq.delete();
        gen_pc = pc;
        refill();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One bench cycle: answer the previous handshake, then drive this cycle's inputs.
    task automatic step(input logic rdy, input logic drdy, input logic jv, input logic [31:0] ja);
        @(negedge clk);
        cyc++;
        if_rdt  = hs_pend ? mem32(hs_adr) : 32'($urandom());
        if_rdy  = rdy;
        dec_rdy = drdy;
        jmp_vld = jv;
        jmp_adr = ja;
        if (jv) restart(jmp_target(ja));
        refill();
        hs_pend = if_vld && if_rdy;
        hs_adr  = if_adr;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_if_vld"},  32'(if_vld),  32'h0);
        chk({tag, "_if_adr"},  if_adr,       PC0 & ~32'h3);
        chk({tag, "_dec_vld"}, 32'(dec_vld), 32'h0);
        chk({tag, "_dec_pc"},  dec_pc,       PC0);
        chk({tag, "_dec_ins"}, dec_ins,      32'h0);
        chk({tag, "_dec_siz"}, 32'(dec_siz), 32'd4);
    endtask

    // Short asynchronous reset pulse inside a cycle, clear of any clock edge.
    task automatic pulse_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        #2 rst = 1'b0;
        #1 check_reset_values("midrst");
        #1 rst = 1'b1;
        restart(PC0);
        pv_ok = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the decoder consumes an instruction.
    logic        pv_vld, pv_rdy, pv_jmp;
    logic [31:0] pv_pc, pv_ins;
    logic [2:0]  pv_siz;
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            if (pv_ok && pv_jmp) chk("vld_after_jmp", 32'(dec_vld), 32'h0);
            if (pv_ok && !pv_jmp && pv_vld && !pv_rdy) begin
                chk("hold_vld", 32'(dec_vld), 32'h1);
                chk("hold_pc",  dec_pc,  pv_pc);
                chk("hold_ins", dec_ins, pv_ins);
            end
            if (if_vld) chk("if_adr_align", 32'(if_adr[1:0]), 32'h0);
            if (dec_vld && dec_rdy && !jmp_vld) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_empty: got pc %h, expected no instruction", dec_pc);
                end else begin
                    e = expq.pop_front();
                    chk("sb_pc",  dec_pc,       e.pc);
                    chk("sb_ins", dec_ins,      e.ins);
                    chk("sb_siz", 32'(dec_siz), 32'(e.siz));
                    n_consumed++;
                end
            end
        end
        pv_ok  = rst;
        pv_vld = dec_vld;
        pv_rdy = dec_rdy;
        pv_jmp = jmp_vld;
        pv_pc  = dec_pc;
        pv_ins = dec_ins;
        pv_siz = dec_siz;
    end

    logic [31:0] hs_list[$];
    int          first_hs;
    int          first_vld;

    initial begin
        restart(PC0);
        repeat (2) @(negedge clk);
        check_reset_values("rst");

        // Startup fill with the decoder stalled.
        @(negedge clk);
        rst = 1'b1;
        first_hs  = -1;
        first_vld = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            if (dec_vld && first_vld < 0) begin
                first_vld = cyc;
                chk("first_dec_pc", dec_pc, PC0);
            end
            if (hs_pend) begin
                if (first_hs < 0) first_hs = cyc;
                hs_list.push_back(hs_adr);
            end
        end
        chk("fill_hs_count", 32'(hs_list.size()), 32'd4);
        for (int i = 0; i < 4 && i < hs_list.size(); i++) begin
            chk("fill_adr", hs_list[i], PC0 + 32'(4 * i));
        end
        chk("fill_latency", 32'(first_vld - first_hs), 32'd2);
        chk("fill_stall", 32'(if_vld), 32'h0);

        // Redirect with three words queued and one response in flight.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("refill_hs", 32'(hs_pend), 32'h1);
        step(1'b1, 1'b0, 1'b1, 32'h0000_2000);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("jmp_dec_vld", 32'(dec_vld), 32'h0);
        chk("jmp_if_adr", if_adr, 32'h0000_2000);

        // Randomized traffic with occasional redirects and reset pulses.
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic [31:0] ja;
            r  = $urandom_range(0, 199);
            ja = (r == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                          : (32'($urandom()) & 32'h0000_7FFF);
            if (i == 1000 || i == 2000) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, r < 4, ja);
            end
        end

        // Fetch address wraps from the top of the address space to zero.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_pre_adr", if_adr, 32'hFFFF_FFFC);
        chk("wrap_pre_vld", 32'(if_vld), 32'h1);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_post_adr", if_adr, 32'h0000_0000);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        chk("progress", 32'(n_consumed > 300), 32'h1);
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
